// File: rtl/accel_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : accel_frame_packer_pkg
// Brief   : Shared types and constants for the accelerometer frame packer.
// Revision: 1.0 - initial release
// ============================================================================
package accel_frame_packer_pkg;

  // Default first byte of every frame
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes per frame and the index width needed to walk them
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  // Byte positions within a frame
  localparam logic [IDX_W-1:0] IDX_SYNC = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_XH   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_XL   = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_YH   = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_YL   = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_ZH   = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_ZL   = IDX_W'(6);
  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(FRAME_LEN - 1);

  // Packer FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // One X/Y/Z sample; X occupies the most significant bits
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

  // XOR of the six data bytes of a sample
  function automatic logic [7:0] frame_checksum(input sample_t s);
    return s.x[15:8] ^ s.x[7:0] ^ s.y[15:8] ^ s.y[7:0] ^ s.z[15:8] ^ s.z[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_frame_byte_sel.sv
`default_nettype none
// ============================================================================
// Module  : accel_frame_byte_sel
// Brief   : Combinational map from {captured sample, byte index} to the frame
//           byte, including the trailing XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
module accel_frame_byte_sel
  import accel_frame_packer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  sample_t          sample,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       frame_byte
);

  // Pick the byte for the current position; the last position carries the checksum
  always_comb begin
    frame_byte = frame_checksum(sample);
    case (idx)
      IDX_SYNC: frame_byte = SYNC_BYTE;
      IDX_XH:   frame_byte = sample.x[15:8];
      IDX_XL:   frame_byte = sample.x[7:0];
      IDX_YH:   frame_byte = sample.y[15:8];
      IDX_YL:   frame_byte = sample.y[7:0];
      IDX_ZH:   frame_byte = sample.z[15:8];
      IDX_ZL:   frame_byte = sample.z[7:0];
      default:  frame_byte = frame_checksum(sample);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/accel_frame_packer.sv
`default_nettype none
// ============================================================================
// Module  : accel_frame_packer
// Brief   : Captures X/Y/Z accelerometer samples and serialises each as an
//           8-byte framed packet on a valid/ready byte stream, with a one-deep
//           pending buffer and a saturating overwrite counter.
// Revision: 1.0 - initial release
// ============================================================================
module accel_frame_packer
  import accel_frame_packer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         DROP_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [15:0]       x_data,
  input  logic [15:0]       y_data,
  input  logic [15:0]       z_data,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count
);

  state_t           r_state;
  sample_t          r_active;
  sample_t          r_pending;
  logic             r_pend_vld;
  logic [IDX_W-1:0] r_idx;
  logic [DROP_W-1:0] r_drop;

  state_t           w_nxt_state;
  sample_t          w_nxt_active;
  sample_t          w_nxt_pending;
  logic             w_nxt_pend_vld;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [DROP_W-1:0] w_nxt_drop;
  logic             w_nxt_valid;
  logic [7:0]       w_nxt_byte;

  sample_t          w_new;
  logic             w_xfer;
  logic             w_take;
  logic             w_last;

  assign w_new  = '{x: x_data, y: y_data, z: z_data};
  assign w_xfer = tx_valid && tx_ready;
  assign w_take = sample_valid && enable;
  assign w_last = (r_state == ST_SEND) && w_xfer && (r_idx == IDX_CHK);

  // Byte presented next cycle is derived from the next active sample and index,
  // so tx_data is registered and only changes on a transfer or a frame start
  accel_frame_byte_sel #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_byte_sel (
    .sample     (w_nxt_active),
    .idx        (w_nxt_idx),
    .frame_byte (w_nxt_byte)
  );

  // Next-state logic: frame sequencing, pending buffer and drop counting
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_active   = r_active;
    w_nxt_pending  = r_pending;
    w_nxt_pend_vld = r_pend_vld;
    w_nxt_idx      = r_idx;
    w_nxt_drop     = r_drop;
    w_nxt_valid    = tx_valid;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_nxt_active = w_new;
          w_nxt_idx    = IDX_SYNC;
          w_nxt_state  = ST_SEND;
          w_nxt_valid  = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_last) begin
          w_nxt_idx = IDX_SYNC;
          if (enable && r_pend_vld) begin
            // Chain straight into the buffered sample; a coincident strobe refills pending
            w_nxt_active = r_pending;
            if (w_take) begin
              w_nxt_pending = w_new;
            end else begin
              w_nxt_pend_vld = 1'b0;
            end
          end else if (w_take) begin
            w_nxt_active = w_new;
          end else begin
            // End of traffic; with enable low any pending sample is silently discarded
            w_nxt_state    = ST_IDLE;
            w_nxt_valid    = 1'b0;
            w_nxt_pend_vld = 1'b0;
          end
        end else begin
          if (w_xfer) begin
            w_nxt_idx = r_idx + IDX_W'(1);
          end
          if (w_take) begin
            w_nxt_pending  = w_new;
            w_nxt_pend_vld = 1'b1;
            if (r_pend_vld && (r_drop != {DROP_W{1'b1}})) begin
              w_nxt_drop = r_drop + DROP_W'(1);
            end
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial frame immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_active   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
      r_idx      <= IDX_SYNC;
      r_drop     <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      r_state    <= w_nxt_state;
      r_active   <= w_nxt_active;
      r_pending  <= w_nxt_pending;
      r_pend_vld <= w_nxt_pend_vld;
      r_idx      <= w_nxt_idx;
      r_drop     <= w_nxt_drop;
      tx_valid   <= w_nxt_valid;
      tx_data    <= w_nxt_byte;
    end
  end

  assign busy       = (r_state == ST_SEND) || r_pend_vld;
  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_accel_frame_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_accel_frame_packer
// Brief   : Scoreboard bench for accel_frame_packer. Stimulus pushes expected
//           bytes; a negedge monitor pops them on every accepted transfer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_accel_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sample_valid;
  logic [15:0] x_data, y_data, z_data;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [7:0]  drop_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  int          mode = 0;      // 0: ready high, 1: random ready, 2: ready low
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  accel_frame_packer #(
    .SYNC_BYTE (8'hA5),
    .DROP_W    (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    logic [7:0] chk;
    chk = x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ z[15:8] ^ z[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(x[15:8]); exp_q.push_back(x[7:0]);
    exp_q.push_back(y[15:8]); exp_q.push_back(y[7:0]);
    exp_q.push_back(z[15:8]); exp_q.push_back(z[7:0]);
    exp_q.push_back(chk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x; y_data = y; z_data = z;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // tx_ready driver: only process that writes tx_ready
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor: on the falling edge, valid&&ready means a transfer at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", tx_valid, 1'b1);
        check("stall_hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", tx_data, exp_q.pop_front());
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    int gap;
    int vcnt;
    rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0;
    x_data = '0; y_data = '0; z_data = '0;
    tick(2);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_count, 8'h00);
    rst_n = 1'b1;
    tick(2);

    // Single frame with literal expected bytes, latency one cycle
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFE); exp_q.push_back(8'h00);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hF2);
    strobe(16'h0102, 16'hFFFE, 16'h00F0);
    check("latency_valid", tx_valid, 1'b1);
    check("latency_sync", tx_data, 8'hA5);
    check("busy_in_frame", busy, 1'b1);
    wait_drain(20, "single");
    check("idle_valid", tx_valid, 1'b0);
    check("idle_busy", busy, 1'b0);

    // Random backpressure
    mode = 1;
    tick(1);
    push_frame(16'h1234, 16'h5678, 16'h9ABC);
    strobe(16'h1234, 16'h5678, 16'h9ABC);
    wait_drain(300, "backpressure");
    mode = 0;
    tick(3);

    // Pending, no drop, no gap between frames
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFE); exp_q.push_back(8'h00);
    exp_q.push_back(8'hF0); exp_q.push_back(8'hF2);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h11); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h33); exp_q.push_back(8'h00);
    strobe(16'h0102, 16'hFFFE, 16'h00F0);
    gap = 0;
    for (int i = 0; i < 16; i++) begin
      if (!tx_valid) gap++;
      if (i == 3) begin
        x_data = 16'h1111; y_data = 16'h2222; z_data = 16'h3333;
        sample_valid = 1'b1;
      end
      if (i == 4) sample_valid = 1'b0;
      tick(1);
    end
    wait_drain(5, "pending");
    check("pending_no_gap", gap, 0);
    check("pending_drop", drop_count, 8'h00);

    // Overflow during a stalled frame: only last sample survives
    mode = 2;
    tick(2);
    push_frame(16'hAAAA, 16'hBBBB, 16'hCCCC);
    push_frame(16'h4040, 16'h5050, 16'h6060);
    strobe(16'hAAAA, 16'hBBBB, 16'hCCCC);
    strobe(16'h1010, 16'h2020, 16'h3030);
    strobe(16'h4040, 16'h5050, 16'h6060);
    tick(3);
    check("ovf_drop1", drop_count, 8'd1);
    check("ovf_stall_sync", tx_data, 8'hA5);
    check("ovf_busy", busy, 1'b1);
    mode = 0;
    wait_drain(40, "overflow");
    check("ovf_drop1_after", drop_count, 8'd1);

    // Saturation of the drop counter
    mode = 2;
    tick(2);
    push_frame(16'hAAAA, 16'hBBBB, 16'hCCCC);
    push_frame(16'd300, 16'd301, 16'd302);
    strobe(16'hAAAA, 16'hBBBB, 16'hCCCC);
    for (int i = 0; i <= 300; i++) begin
      x_data = 16'(i); y_data = 16'(i + 1); z_data = 16'(i + 2);
      sample_valid = 1'b1;
      tick(1);
    end
    sample_valid = 1'b0;
    check("drop_saturated", drop_count, 8'hFF);
    mode = 0;
    wait_drain(40, "saturate");
    check("drop_saturated_hold", drop_count, 8'hFF);

    // Asynchronous reset mid-frame at byte 4
    tick(1);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h13); exp_q.push_back(8'h57);
    exp_q.push_back(8'h24);
    strobe(16'h1357, 16'h2468, 16'h9ABC);
    tick(4);
    check("byte4_presented", tx_data, 8'h68);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", tx_valid, 1'b0);
    check("async_rst_data", tx_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_drop", drop_count, 8'h00);
    check("async_rst_partial", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    push_frame(16'h0F0F, 16'hF0F0, 16'h5555);
    strobe(16'h0F0F, 16'hF0F0, 16'h5555);
    check("post_rst_sync", tx_data, 8'hA5);
    wait_drain(20, "post_reset");

    // Strobe coincident with the last transfer, pending empty
    tick(2);
    push_frame(16'hC001, 16'hC002, 16'hC003);
    push_frame(16'hD001, 16'hD002, 16'hD003);
    strobe(16'hC001, 16'hC002, 16'hC003);
    tick(7);
    strobe(16'hD001, 16'hD002, 16'hD003);
    wait_drain(30, "simul_empty");
    check("simul_empty_drop", drop_count, 8'h00);

    // Strobe coincident with the last transfer, pending full
    tick(2);
    push_frame(16'hE001, 16'hE002, 16'hE003);
    push_frame(16'hE101, 16'hE102, 16'hE103);
    push_frame(16'hE201, 16'hE202, 16'hE203);
    strobe(16'hE001, 16'hE002, 16'hE003);
    tick(1);
    strobe(16'hE101, 16'hE102, 16'hE103);
    tick(5);
    strobe(16'hE201, 16'hE202, 16'hE203);
    wait_drain(40, "simul_full");
    check("simul_full_drop", drop_count, 8'h00);

    // Enable dropped mid-frame: frame completes, pending discarded
    tick(2);
    push_frame(16'h7001, 16'h7002, 16'h7003);
    strobe(16'h7001, 16'h7002, 16'h7003);
    tick(1);
    strobe(16'h7101, 16'h7102, 16'h7103);
    enable = 1'b0;
    check("en_busy", busy, 1'b1);
    strobe(16'h7201, 16'h7202, 16'h7203);
    wait_drain(30, "enable_off");
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) vcnt++;
      tick(1);
    end
    check("en_no_more_frames", vcnt, 0);
    check("en_idle_busy", busy, 1'b0);
    check("en_drop", drop_count, 8'h00);
    enable = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
